urv_trap_ctrl: RTL and testbench

Trap and interrupt sequencer for the uRV core. Owns the machine-mode trap state (mstatus, mie, mip, mepc, mcause) that the CSR unit reads, and commits CSR writes to those registers. Decides in the execute stage when a synchronous exception, external interrupt or timer interrupt is taken, or when an `mret` returns. Issues a one-cycle pipeline redirect and kill for each taken event.

---
 rtl/urv_trap_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_urv_trap_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap and interrupt sequencer for the uRV core.
// Define URV_TRAP_TIMER_IRQ_EN to build the internal timer interrupt source (MTIP/MTIE).
module urv_trap_ctrl #(
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0008,
    parameter int unsigned TIMER_PERIOD = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        x_valid_i,
    input  logic [31:0] x_pc_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic        x_is_mret_i,
    input  logic        d_is_csr_i,
    input  logic [11:0] d_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        irq_i,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o,
    output logic        x_redirect_o,
    output logic [31:0] x_redirect_pc_o,
    output logic        x_trap_kill_o
);

    // state    | meaning
    // IDLE     | accepting instructions, events may be taken
    // REDIRECT | redirect and kill pulse driven this cycle
    // FLUSH    | killed bubble drains, execute ignored
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [11:0] CSR_ID_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ID_MIE     = 12'h304;
    localparam logic [11:0] CSR_ID_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ID_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_ID_MIP     = 12'h344;

    state_t      state_q;
    logic        redirect_q, kill_q;
    logic [31:0] redirect_pc_q;

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        meie_q, meie_d;
    logic        mtie_q, mtie_d;
    logic        mtip_q, mtip_d;
    logic        meip_q;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic go, irq_ext, irq_tmr, take_trap, take_mret, csr_wr;

    assign go        = x_valid_i & ~x_stall_i & ~x_kill_i & (state_q == ST_IDLE);
    assign irq_ext   = mie_q & meie_q & meip_q;
    assign irq_tmr   = mie_q & mtie_q & mtip_q;
    assign take_trap = go & (x_exception_i | irq_ext | irq_tmr);
    assign take_mret = go & ~take_trap & x_is_mret_i;
    assign csr_wr    = go & ~take_trap & ~take_mret & d_is_csr_i;

`ifdef URV_TRAP_TIMER_IRQ_EN
    localparam int unsigned TMR_W = (TIMER_PERIOD > 2) ? $clog2(TIMER_PERIOD) : 1;

    logic [TMR_W-1:0] tmr_cnt_q;
    logic             tmr_wrap;
    logic             mtip_clr;

    assign tmr_wrap = (tmr_cnt_q == TMR_W'(TIMER_PERIOD - 1));
    assign mtip_clr = csr_wr & (d_csr_sel_i == CSR_ID_MIP) & ~x_csr_write_value_i[7];
    // A wrap coinciding with a software clear leaves MTIP set.
    assign mtip_d   = tmr_wrap | (mtip_q & ~mtip_clr);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmr_cnt_q <= '0;
        end else begin
            tmr_cnt_q <= tmr_wrap ? '0 : tmr_cnt_q + TMR_W'(1);
        end
    end
`else
    logic unused_timer_period;

    assign unused_timer_period = (TIMER_PERIOD < 2);
    assign mtip_d              = 1'b0;
`endif

    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        meie_d   = meie_q;
        mtie_d   = mtie_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (take_trap) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
            mepc_d = x_pc_i & 32'hFFFF_FFFC;
            if (x_exception_i) begin
                mcause_d = {28'h0, x_exception_cause_i};
            end else if (irq_ext) begin
                mcause_d = 32'h8000_000B;
            end else begin
                mcause_d = 32'h8000_0007;
            end
        end else if (take_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_wr) begin
            case (d_csr_sel_i)
                CSR_ID_MSTATUS: begin
                    mie_d  = x_csr_write_value_i[3];
                    mpie_d = x_csr_write_value_i[7];
                end
                CSR_ID_MIE: begin
                    meie_d = x_csr_write_value_i[11];
`ifdef URV_TRAP_TIMER_IRQ_EN
                    mtie_d = x_csr_write_value_i[7];
`endif
                end
                CSR_ID_MEPC:   mepc_d   = x_csr_write_value_i & 32'hFFFF_FFFC;
                CSR_ID_MCAUSE: mcause_d = x_csr_write_value_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            mtip_q   <= 1'b0;
            meip_q   <= 1'b0;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            meie_q   <= meie_d;
            mtie_q   <= mtie_d;
            mtip_q   <= mtip_d;
            meip_q   <= irq_i;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    // Redirect/kill sequencing; runs through REDIRECT and FLUSH regardless of stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            redirect_q    <= 1'b0;
            kill_q        <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_trap || take_mret) begin
                        state_q       <= ST_REDIRECT;
                        redirect_q    <= 1'b1;
                        kill_q        <= 1'b1;
                        redirect_pc_q <= take_trap ? TRAP_VECTOR : mepc_q;
                    end
                end
                ST_REDIRECT: begin
                    state_q    <= ST_FLUSH;
                    redirect_q <= 1'b0;
                    kill_q     <= 1'b0;
                end
                ST_FLUSH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    redirect_q <= 1'b0;
                    kill_q     <= 1'b0;
                end
            endcase
        end
    end

    assign csr_mstatus_o   = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
    assign csr_mie_o       = {20'h0, meie_q, 3'b000, mtie_q, 7'h00};
    assign csr_mip_o       = {20'h0, meip_q, 3'b000, mtip_q, 7'h00};
    assign csr_mepc_o      = mepc_q;
    assign csr_mcause_o    = mcause_q;
    assign x_redirect_o    = redirect_q;
    assign x_redirect_pc_o = redirect_pc_q;
    assign x_trap_kill_o   = kill_q;

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Self-checking bench for urv_trap_ctrl: CSR write table, directed trap/mret/irq/reset
// sequences, timer sequence (when URV_TRAP_TIMER_IRQ_EN is defined) and randomized run.
module tb_urv_trap_ctrl;
    localparam int TP = 10;
`ifdef URV_TRAP_TIMER_IRQ_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        x_stall_i, x_kill_i, x_valid_i, x_exception_i, x_is_mret_i, d_is_csr_i, irq_i;
    logic [31:0] x_pc_i, x_csr_write_value_i;
    logic [3:0]  x_exception_cause_i;
    logic [11:0] d_csr_sel_i;
    logic [31:0] csr_mstatus_o, csr_mie_o, csr_mip_o, csr_mepc_o, csr_mcause_o, x_redirect_pc_o;
    logic        x_redirect_o, x_trap_kill_o;

    always #5 clk_i = ~clk_i;

    urv_trap_ctrl #(.TRAP_VECTOR(32'h0000_0008), .TIMER_PERIOD(TP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
        .x_valid_i(x_valid_i), .x_pc_i(x_pc_i), .x_exception_i(x_exception_i),
        .x_exception_cause_i(x_exception_cause_i), .x_is_mret_i(x_is_mret_i),
        .d_is_csr_i(d_is_csr_i), .d_csr_sel_i(d_csr_sel_i),
        .x_csr_write_value_i(x_csr_write_value_i), .irq_i(irq_i),
        .csr_mstatus_o(csr_mstatus_o), .csr_mie_o(csr_mie_o), .csr_mip_o(csr_mip_o),
        .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o), .x_redirect_o(x_redirect_o),
        .x_redirect_pc_o(x_redirect_pc_o), .x_trap_kill_o(x_trap_kill_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic exc,
                         input logic [3:0] cause, input logic mret, input logic csr,
                         input logic [11:0] sel, input logic [31:0] wv);
        x_stall_i = 1'b0; x_kill_i = 1'b0;
        x_valid_i = v; x_pc_i = pc; x_exception_i = exc; x_exception_cause_i = cause;
        x_is_mret_i = mret; d_is_csr_i = csr; d_csr_sel_i = sel; x_csr_write_value_i = wv;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic csr_write(input logic [11:0] sel, input logic [31:0] wv);
        drive(1'b1, 32'h40, 1'b0, 4'h0, 1'b0, 1'b1, sel, wv);
    endtask

    // Reference model: architectural trap state plus a cycles-until-idle count.
    bit          m_mie, m_mpie, m_meie, m_mtie, m_meip, m_mtip, m_redir;
    logic [31:0] m_mepc, m_mcause, m_rpc;
    int          m_busy, m_cyc;

    task automatic mdl_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0; m_mtie = 0; m_meip = 0; m_mtip = 0; m_redir = 0;
        m_mepc = 0; m_mcause = 0; m_rpc = 0; m_busy = 0; m_cyc = 0;
    endtask

    task automatic mdl_step();
        bit go, ext, tmr, clr;
        go  = x_valid_i && !x_stall_i && !x_kill_i && (m_busy == 0);
        ext = m_mie && m_meie && m_meip;
        tmr = m_mie && m_mtie && m_mtip;
        clr = 0;
        m_busy  = (m_busy > 0) ? m_busy - 1 : 0;
        m_redir = 0;
        if (go && (x_exception_i || ext || tmr)) begin
            m_mepc   = {x_pc_i[31:2], 2'b00};
            m_mcause = x_exception_i ? {28'h0, x_exception_cause_i}
                                     : (ext ? 32'h8000_000B : 32'h8000_0007);
            m_mpie = m_mie; m_mie = 0;
            m_busy = 2; m_redir = 1; m_rpc = 32'h8;
        end else if (go && x_is_mret_i) begin
            m_rpc = m_mepc; m_mie = m_mpie; m_mpie = 1;
            m_busy = 2; m_redir = 1;
        end else if (go && d_is_csr_i) begin
            case (d_csr_sel_i)
                12'h300: begin m_mie = x_csr_write_value_i[3]; m_mpie = x_csr_write_value_i[7]; end
                12'h304: begin
                    m_meie = x_csr_write_value_i[11];
                    if (TIMER_ON) m_mtie = x_csr_write_value_i[7];
                end
                12'h341: m_mepc = {x_csr_write_value_i[31:2], 2'b00};
                12'h342: m_mcause = x_csr_write_value_i;
                12'h344: clr = !x_csr_write_value_i[7];
                default: ;
            endcase
        end
        m_meip = irq_i;
        if (TIMER_ON) begin
            m_cyc++;
            if (clr) m_mtip = 0;
            if (m_cyc % TP == 0) m_mtip = 1;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        irq_i = 1'b0;
        idle();
        tick();
        rst_i = 1'b0;
        mdl_reset();
    endtask

    typedef struct {
        logic [11:0] sel;
        logic [31:0] wv;
        logic [31:0] exp_mstatus;
        logic [31:0] exp_mie;
        logic [31:0] exp_mepc;
        logic [31:0] exp_mcause;
    } csr_vec_t;

    csr_vec_t tbl[8];

    initial begin
        irq_i = 1'b0;
        idle();
        tbl[0] = '{12'h300, 32'hFFFF_FFFF, 32'h88, 32'h000, 32'h0,         32'h0};
        tbl[1] = '{12'h304, 32'hFFFF_FF7F, 32'h88, 32'h800, 32'h0,         32'h0};
        tbl[2] = '{12'h341, 32'h1234_5677, 32'h88, 32'h800, 32'h1234_5674, 32'h0};
        tbl[3] = '{12'h342, 32'hDEAD_BEEF, 32'h88, 32'h800, 32'h1234_5674, 32'hDEAD_BEEF};
        tbl[4] = '{12'h300, 32'h0000_0008, 32'h08, 32'h800, 32'h1234_5674, 32'hDEAD_BEEF};
        tbl[5] = '{12'h333, 32'hFFFF_FFFF, 32'h08, 32'h800, 32'h1234_5674, 32'hDEAD_BEEF};
        tbl[6] = '{12'h344, 32'h0000_0000, 32'h08, 32'h800, 32'h1234_5674, 32'hDEAD_BEEF};
        tbl[7] = '{12'h300, 32'h0000_0080, 32'h80, 32'h800, 32'h1234_5674, 32'hDEAD_BEEF};

        // Reset state
        do_reset();
        chk("reset_mstatus", csr_mstatus_o, 32'h0);
        chk("reset_mie", csr_mie_o, 32'h0);
        chk("reset_mip", csr_mip_o, 32'h0);
        chk("reset_mepc", csr_mepc_o, 32'h0);
        chk("reset_mcause", csr_mcause_o, 32'h0);
        chk("reset_redirect", {31'h0, x_redirect_o}, 32'h0);
        chk("reset_kill", {31'h0, x_trap_kill_o}, 32'h0);

        // CSR write table
        for (int i = 0; i < 8; i++) begin
            csr_write(tbl[i].sel, tbl[i].wv);
            tick();
            chk($sformatf("tbl%0d_mstatus", i), csr_mstatus_o, tbl[i].exp_mstatus);
            chk($sformatf("tbl%0d_mie", i), csr_mie_o & 32'h800, tbl[i].exp_mie);
            chk($sformatf("tbl%0d_mepc", i), csr_mepc_o, tbl[i].exp_mepc);
            chk($sformatf("tbl%0d_mcause", i), csr_mcause_o, tbl[i].exp_mcause);
            chk($sformatf("tbl%0d_redirect", i), {31'h0, x_redirect_o}, 32'h0);
        end

        // Exception, then writes ignored through REDIRECT and FLUSH, then mret
        do_reset();
        csr_write(12'h300, 32'h08);
        tick();
        drive(1'b1, 32'h100, 1'b1, 4'h2, 1'b0, 1'b0, 12'h0, 32'h0);
        tick();
        chk("exc_redirect", {31'h0, x_redirect_o}, 32'h1);
        chk("exc_kill", {31'h0, x_trap_kill_o}, 32'h1);
        chk("exc_pc", x_redirect_pc_o, 32'h8);
        chk("exc_mepc", csr_mepc_o, 32'h100);
        chk("exc_mcause", csr_mcause_o, 32'h2);
        chk("exc_mstatus", csr_mstatus_o, 32'h80);
        csr_write(12'h342, 32'hFFFF);
        tick();
        chk("exc_redirect_pulse", {31'h0, x_redirect_o}, 32'h0);
        chk("redirect_ignores_csr", csr_mcause_o, 32'h2);
        tick();
        chk("flush_ignores_csr", csr_mcause_o, 32'h2);
        drive(1'b1, 32'h104, 1'b0, 4'h0, 1'b1, 1'b0, 12'h0, 32'h0);
        tick();
        chk("mret_redirect", {31'h0, x_redirect_o}, 32'h1);
        chk("mret_pc", x_redirect_pc_o, 32'h100);
        chk("mret_mstatus", csr_mstatus_o, 32'h88);
        idle();
        tick();
        tick();

        // External IRQ with a simultaneous MSTATUS write that must be discarded
        csr_write(12'h304, 32'h800);
        irq_i = 1'b1;
        tick();
        chk("meip_visible", csr_mip_o & 32'h800, 32'h800);
        drive(1'b1, 32'h200, 1'b0, 4'h0, 1'b0, 1'b1, 12'h300, 32'h0);
        tick();
        chk("irq_redirect", {31'h0, x_redirect_o}, 32'h1);
        chk("irq_mcause", csr_mcause_o, 32'h8000_000B);
        chk("irq_mepc", csr_mepc_o, 32'h200);
        chk("irq_csr_discarded", csr_mstatus_o, 32'h80);
        idle();
        tick();
        chk("irq_redirect_pulse", {31'h0, x_redirect_o}, 32'h0);
        tick();

        // IRQ pending but MIE=0: no trap
        drive(1'b1, 32'h300, 1'b0, 4'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        tick();
        chk("irq_masked_redirect", {31'h0, x_redirect_o}, 32'h0);
        chk("irq_masked_mepc", csr_mepc_o, 32'h200);

        // Exception and IRQ together: exception wins
        csr_write(12'h300, 32'h08);
        tick();
        chk("reenable_mstatus", csr_mstatus_o, 32'h08);
        drive(1'b1, 32'h400, 1'b1, 4'h5, 1'b0, 1'b0, 12'h0, 32'h0);
        tick();
        chk("exc_irq_mcause", csr_mcause_o, 32'h5);
        chk("exc_irq_mepc", csr_mepc_o, 32'h400);
        chk("exc_irq_redirect", {31'h0, x_redirect_o}, 32'h1);

        // Reset during REDIRECT
        idle();
        rst_i = 1'b1;
        #1;
        chk("rst_mid_redirect", {31'h0, x_redirect_o}, 32'h0);
        chk("rst_mid_mstatus", csr_mstatus_o, 32'h0);
        chk("rst_mid_mepc", csr_mepc_o, 32'h0);
        chk("rst_mid_mcause", csr_mcause_o, 32'h0);
        tick();
        chk("rst_held_redirect", {31'h0, x_redirect_o}, 32'h0);
        chk("rst_held_kill", {31'h0, x_trap_kill_o}, 32'h0);
        chk("rst_held_mip", csr_mip_o, 32'h0);
        irq_i = 1'b0;
        rst_i = 1'b0;
        mdl_reset();

`ifdef URV_TRAP_TIMER_IRQ_EN
        do_reset();
        csr_write(12'h304, 32'h80);
        tick();
        csr_write(12'h300, 32'h08);
        tick();
        idle();
        repeat (7) tick();
        chk("tmr_mtip_edge9", csr_mip_o, 32'h0);
        tick();
        chk("tmr_mtip_edge10", csr_mip_o, 32'h80);
        drive(1'b1, 32'h500, 1'b0, 4'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        tick();
        chk("tmr_redirect", {31'h0, x_redirect_o}, 32'h1);
        chk("tmr_mcause", csr_mcause_o, 32'h8000_0007);
        chk("tmr_mepc", csr_mepc_o, 32'h500);
        idle();
        tick();
        tick();
        csr_write(12'h344, 32'h0);
        tick();
        chk("tmr_mtip_cleared", csr_mip_o, 32'h0);
`endif

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                continue;
            end
            x_valid_i     = ($urandom_range(0, 9) < 7);
            x_stall_i     = ($urandom_range(0, 9) < 2);
            x_kill_i      = ($urandom_range(0, 9) < 1);
            x_pc_i        = $urandom;
            x_exception_i = ($urandom_range(0, 9) < 1);
            x_exception_cause_i = 4'($urandom_range(0, 15));
            x_is_mret_i   = ($urandom_range(0, 9) < 2);
            d_is_csr_i    = ($urandom_range(0, 9) < 5);
            case ($urandom_range(0, 5))
                0: d_csr_sel_i = 12'h300;
                1: d_csr_sel_i = 12'h304;
                2: d_csr_sel_i = 12'h341;
                3: d_csr_sel_i = 12'h342;
                4: d_csr_sel_i = 12'h344;
                default: d_csr_sel_i = 12'($urandom);
            endcase
            x_csr_write_value_i = $urandom;
            if ($urandom_range(0, 15) == 0) irq_i = ~irq_i;
            mdl_step();
            tick();
            chk("rnd_mstatus", csr_mstatus_o, (32'(m_mpie) << 7) | (32'(m_mie) << 3));
            chk("rnd_mie", csr_mie_o, (32'(m_meie) << 11) | (32'(m_mtie) << 7));
            chk("rnd_mip", csr_mip_o, (32'(m_meip) << 11) | (32'(m_mtip) << 7));
            chk("rnd_mepc", csr_mepc_o, m_mepc);
            chk("rnd_mcause", csr_mcause_o, m_mcause);
            chk("rnd_redirect", {31'h0, x_redirect_o}, {31'h0, m_redir});
            chk("rnd_kill", {31'h0, x_trap_kill_o}, {31'h0, m_redir});
            if (m_redir) chk("rnd_redirect_pc", x_redirect_pc_o, m_rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
